// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall, flush, sticky halt and control-conflict error.
// Optional stall-cycle counter enabled by defining EX_MEM_PERF_EN.
module ex_mem_latch #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_In,
  input  logic [7:0]        Ctrl_In,
  input  logic [3:0]        Flags_In,
  input  logic [2:0]        SelFlag_In,
  input  logic [REG_W-1:0]  WR_In,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] RD2_In,
  input  logic [DATA_W-1:0] BJAddr_In,
  input  logic [DATA_W-1:0] PCInc_In,
  output logic              Valid_Out,
  output logic [7:0]        Ctrl_Out,
  output logic [3:0]        Flags_Out,
  output logic [2:0]        SelFlag_Out,
  output logic [REG_W-1:0]  WR_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [DATA_W-1:0] RD2_Out,
  output logic [DATA_W-1:0] BJAddr_Out,
  output logic [DATA_W-1:0] PCInc_Out,
  output logic              Halted,
  output logic              err,
  output logic [15:0]       StallCnt
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [7:0]          ctrl_q, ctrl_d;
  logic [3:0]          flags_q, flags_d;
  logic [2:0]          sel_q, sel_d;
  logic [REG_W-1:0]    wr_q, wr_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   bj_q, bj_d;
  logic [DATA_W-1:0]   pcinc_q, pcinc_d;
  logic                err_q, err_d;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    flags_d = flags_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    alu_d   = alu_q;
    rd2_d   = rd2_q;
    bj_d    = bj_q;
    pcinc_d = pcinc_q;
    err_d   = err_q;
    if (state_q == S_RUN) begin
      if (Flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (!Stall) begin
        valid_d = Valid_In;
        ctrl_d  = Valid_In ? Ctrl_In : '0;
        flags_d = Flags_In;
        sel_d   = SelFlag_In;
        wr_d    = WR_In;
        alu_d   = ALUResult_In;
        rd2_d   = RD2_In;
        bj_d    = BJAddr_In;
        pcinc_d = PCInc_In;
        // Ctrl_In[0] is Halt; [2]/[1] are MemReadEn/MemWriteEn
        if (Valid_In && Ctrl_In[0]) state_d = S_HALTED;
        if (Valid_In && Ctrl_In[2] && Ctrl_In[1]) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      flags_q <= '0;
      sel_q   <= '0;
      wr_q    <= '0;
      alu_q   <= '0;
      rd2_q   <= '0;
      bj_q    <= '0;
      pcinc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      alu_q   <= alu_d;
      rd2_q   <= rd2_d;
      bj_q    <= bj_d;
      pcinc_q <= pcinc_d;
      err_q   <= err_d;
    end
  end

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_RUN && Stall && !Flush && valid_q && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = '0;
`endif

  assign Valid_Out     = valid_q;
  assign Ctrl_Out      = ctrl_q;
  assign Flags_Out     = flags_q;
  assign SelFlag_Out   = sel_q;
  assign WR_Out        = wr_q;
  assign ALUResult_Out = alu_q;
  assign RD2_Out       = rd2_q;
  assign BJAddr_Out    = bj_q;
  assign PCInc_Out     = pcinc_q;
  assign Halted        = (state_q == S_HALTED);
  assign err           = err_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed self-checking bench for ex_mem_latch; StallCnt expectations follow EX_MEM_PERF_EN.
module tb_ex_mem_latch;
  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Flush, Valid_In;
  logic [7:0]  Ctrl_In;
  logic [3:0]  Flags_In;
  logic [2:0]  SelFlag_In;
  logic [2:0]  WR_In;
  logic [15:0] ALUResult_In, RD2_In, BJAddr_In, PCInc_In;
  logic        Valid_Out;
  logic [7:0]  Ctrl_Out;
  logic [3:0]  Flags_Out;
  logic [2:0]  SelFlag_Out;
  logic [2:0]  WR_Out;
  logic [15:0] ALUResult_Out, RD2_Out, BJAddr_Out, PCInc_Out;
  logic        Halted, err;
  logic [15:0] StallCnt;

  int checks = 0;
  int failures = 0;

`ifdef EX_MEM_PERF_EN
  localparam logic [15:0] STALL3 = 16'd3;
`else
  localparam logic [15:0] STALL3 = 16'd0;
`endif

  ex_mem_latch #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
    .Ctrl_In(Ctrl_In), .Flags_In(Flags_In), .SelFlag_In(SelFlag_In), .WR_In(WR_In),
    .ALUResult_In(ALUResult_In), .RD2_In(RD2_In), .BJAddr_In(BJAddr_In), .PCInc_In(PCInc_In),
    .Valid_Out(Valid_Out), .Ctrl_Out(Ctrl_Out), .Flags_Out(Flags_Out), .SelFlag_Out(SelFlag_Out),
    .WR_Out(WR_Out), .ALUResult_Out(ALUResult_Out), .RD2_Out(RD2_Out), .BJAddr_Out(BJAddr_Out),
    .PCInc_Out(PCInc_Out), .Halted(Halted), .err(err), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; Stall = 0; Flush = 0; Valid_In = 0; Ctrl_In = '0; Flags_In = '0;
    SelFlag_In = '0; WR_In = '0; ALUResult_In = '0; RD2_In = '0; BJAddr_In = '0; PCInc_In = '0;
    step();
    checks++;
    if ({Valid_Out, Ctrl_Out, Flags_Out, SelFlag_Out, WR_Out, ALUResult_Out, RD2_Out,
         BJAddr_Out, PCInc_Out, Halted, err, StallCnt} !== '0) begin
      failures++; $display("FAIL reset_all_zero got valid=%0h ctrl=%0h alu=%0h halted=%0h err=%0h cnt=%0h exp all 0",
                           Valid_Out, Ctrl_Out, ALUResult_Out, Halted, err, StallCnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_load();
    Valid_In = 1; Ctrl_In = 8'h84; ALUResult_In = 16'h1234; WR_In = 3'd5;
    Flags_In = 4'hA; SelFlag_In = 3'd6; RD2_In = 16'h5555; BJAddr_In = 16'h0400; PCInc_In = 16'h0012;
    step();
    checks++; if (Valid_Out !== 1'b1) begin failures++; $display("FAIL load_valid got=%0h exp=1", Valid_Out); end
    checks++; if (Ctrl_Out !== 8'h84) begin failures++; $display("FAIL load_ctrl got=%0h exp=84", Ctrl_Out); end
    checks++; if (ALUResult_Out !== 16'h1234) begin failures++; $display("FAIL load_alu got=%0h exp=1234", ALUResult_Out); end
    checks++; if (WR_Out !== 3'd5) begin failures++; $display("FAIL load_wr got=%0h exp=5", WR_Out); end
    checks++;
    if ({Flags_Out, SelFlag_Out, RD2_Out, BJAddr_Out, PCInc_Out} !== {4'hA, 3'd6, 16'h5555, 16'h0400, 16'h0012}) begin
      failures++; $display("FAIL load_fields got flags=%0h sel=%0h rd2=%0h bj=%0h pc=%0h exp a/6/5555/400/12",
                           Flags_Out, SelFlag_Out, RD2_Out, BJAddr_Out, PCInc_Out);
    end
    checks++; if (Halted !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL load_status got halted=%0h err=%0h exp 0/0", Halted, err); end
  endtask

  task automatic test_stall();
    Stall = 1; ALUResult_In = 16'hBEEF; RD2_In = 16'hAAAA; Ctrl_In = 8'h10; WR_In = 3'd1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (ALUResult_Out !== 16'h1234) begin failures++; $display("FAIL stall_alu got=%0h exp=1234", ALUResult_Out); end
    checks++; if (RD2_Out !== 16'h5555 || WR_Out !== 3'd5) begin failures++; $display("FAIL stall_fields got rd2=%0h wr=%0h exp 5555/5", RD2_Out, WR_Out); end
    checks++; if (Ctrl_Out !== 8'h84 || Valid_Out !== 1'b1) begin failures++; $display("FAIL stall_ctrl got ctrl=%0h valid=%0h exp 84/1", Ctrl_Out, Valid_Out); end
    checks++; if (StallCnt !== STALL3) begin failures++; $display("FAIL stall_cnt got=%0h exp=%0h", StallCnt, STALL3); end
  endtask

  task automatic test_flush_priority();
    Stall = 1; Flush = 1;
    step();
    checks++; if (Valid_Out !== 1'b0 || Ctrl_Out !== 8'h00) begin failures++; $display("FAIL flush_bubble got valid=%0h ctrl=%0h exp 0/0", Valid_Out, Ctrl_Out); end
    checks++; if (ALUResult_Out !== 16'h1234 || Flags_Out !== 4'hA || WR_Out !== 3'd5) begin
      failures++; $display("FAIL flush_hold got alu=%0h flags=%0h wr=%0h exp 1234/a/5", ALUResult_Out, Flags_Out, WR_Out);
    end
    checks++; if (StallCnt !== STALL3) begin failures++; $display("FAIL flush_cnt got=%0h exp=%0h", StallCnt, STALL3); end
    // bubble in Valid_Out: a further stall must not count
    Flush = 0;
    step();
    checks++; if (StallCnt !== STALL3) begin failures++; $display("FAIL stall_bubble_cnt got=%0h exp=%0h", StallCnt, STALL3); end
  endtask

  task automatic test_invalid_slot();
    Stall = 0; Flush = 0; Valid_In = 0; Ctrl_In = 8'hFF; ALUResult_In = 16'h7777;
    step();
    checks++; if (Ctrl_Out !== 8'h00 || Valid_Out !== 1'b0) begin failures++; $display("FAIL invalid_ctrl got ctrl=%0h valid=%0h exp 0/0", Ctrl_Out, Valid_Out); end
    checks++; if (Halted !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL invalid_status got halted=%0h err=%0h exp 0/0", Halted, err); end
    checks++; if (ALUResult_Out !== 16'h7777) begin failures++; $display("FAIL invalid_data got=%0h exp=7777", ALUResult_Out); end
  endtask

  task automatic test_flush_halt();
    Flush = 1; Valid_In = 1; Ctrl_In = 8'h01;
    step();
    checks++; if (Halted !== 1'b0 || Ctrl_Out !== 8'h00) begin failures++; $display("FAIL flush_halt got halted=%0h ctrl=%0h exp 0/0", Halted, Ctrl_Out); end
    Flush = 0; Valid_In = 1; Ctrl_In = 8'h80; ALUResult_In = 16'h0101;
    step();
    checks++; if (Ctrl_Out !== 8'h80 || ALUResult_Out !== 16'h0101) begin failures++; $display("FAIL after_flush_halt_load got ctrl=%0h alu=%0h exp 80/101", Ctrl_Out, ALUResult_Out); end
  endtask

  task automatic test_halt_freeze();
    Valid_In = 1; Ctrl_In = 8'h01; PCInc_In = 16'h0020; ALUResult_In = 16'h0A0A; WR_In = 3'd2;
    step();
    checks++; if (Halted !== 1'b1 || Ctrl_Out !== 8'h01) begin failures++; $display("FAIL halt_latch got halted=%0h ctrl=%0h exp 1/01", Halted, Ctrl_Out); end
    checks++; if (PCInc_Out !== 16'h0020 || ALUResult_Out !== 16'h0A0A) begin failures++; $display("FAIL halt_data got pc=%0h alu=%0h exp 20/a0a", PCInc_Out, ALUResult_Out); end
    for (int i = 0; i < 5; i++) begin
      Flush = (i != 2); Stall = (i >= 2); Valid_In = 1; Ctrl_In = 8'h84;
      ALUResult_In = 16'hC000 + 16'(i); PCInc_In = 16'hF0F0; WR_In = 3'd7;
      step();
      checks++;
      if ({Halted, Valid_Out, Ctrl_Out, ALUResult_Out, PCInc_Out, WR_Out, StallCnt} !==
          {1'b1, 1'b1, 8'h01, 16'h0A0A, 16'h0020, 3'd2, STALL3}) begin
        failures++; $display("FAIL halt_freeze[%0d] got halted=%0h valid=%0h ctrl=%0h alu=%0h pc=%0h wr=%0h cnt=%0h", i,
                             Halted, Valid_Out, Ctrl_Out, ALUResult_Out, PCInc_Out, WR_Out, StallCnt);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({Valid_Out, Ctrl_Out, ALUResult_Out, PCInc_Out, WR_Out, Halted, err, StallCnt} !== '0) begin
      failures++; $display("FAIL halt_reset got halted=%0h ctrl=%0h alu=%0h pc=%0h cnt=%0h exp all 0",
                           Halted, Ctrl_Out, ALUResult_Out, PCInc_Out, StallCnt);
    end
    Flush = 0; Stall = 0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_error();
    Valid_In = 1; Ctrl_In = 8'h06; ALUResult_In = 16'h3000;
    step();
    checks++; if (err !== 1'b1 || Ctrl_Out !== 8'h06) begin failures++; $display("FAIL err_set got err=%0h ctrl=%0h exp 1/06", err, Ctrl_Out); end
    Ctrl_In = 8'h84;
    step(); step();
    checks++; if (err !== 1'b1 || Ctrl_Out !== 8'h84) begin failures++; $display("FAIL err_sticky got err=%0h ctrl=%0h exp 1/84", err, Ctrl_Out); end
    Valid_In = 0; Ctrl_In = 8'h06;
    step();
    Stall = 1; Valid_In = 1; Ctrl_In = 8'h84;
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || Valid_Out !== 1'b0) begin failures++; $display("FAIL err_reset got err=%0h valid=%0h exp 0/0", err, Valid_Out); end
    Stall = 0; Valid_In = 0; Ctrl_In = 8'h06;
    step();
    rst = 1'b1;
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_invalid_slot got=%0h exp=0", err); end
  endtask

  task automatic test_back_to_back();
    Valid_In = 1; Ctrl_In = 8'hA0; ALUResult_In = 16'h1111;
    step();
    Ctrl_In = 8'h48; ALUResult_In = 16'h2222;
    step();
    checks++; if (Ctrl_Out !== 8'h48 || ALUResult_Out !== 16'h2222) begin failures++; $display("FAIL b2b got ctrl=%0h alu=%0h exp 48/2222", Ctrl_Out, ALUResult_Out); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_priority();
    test_invalid_slot();
    test_flush_halt();
    test_halt_freeze();
    test_error();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Pipeline register between the execute stage and the memory stage.
- Captures execute-stage control, flags and data each cycle, and supports stall (hold) and flush (bubble insertion).
- Tracks a sticky halt state so the memory stage sees a stable Halt once it has been latched.
- Reports a registered control-conflict error and, optionally, a stall-cycle performance counter.

Parameters:
DATA_W, 16, width of the ALU result, store data, branch/jump address and PC+2 fields
REG_W, 3, width of the register-file write-address field

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset asserted)
Stall  in  1  hold all registers this edge
Flush  in  1  insert a bubble this edge; has priority over Stall
Valid_In  in  1  execute-stage instruction is valid
Ctrl_In  in  8  {RegWriteEn, RegWriteDataSel[1:0], Branch, Jump, MemReadEn, MemWriteEn, Halt}
Flags_In  in  4  {Ofl, Z, N, Cout} from the ALU
SelFlag_In  in  3  branch-condition select
WR_In  in  REG_W  destination register
ALUResult_In  in  DATA_W  ALU result / memory address
RD2_In  in  DATA_W  store data
BJAddr_In  in  DATA_W  branch/jump target
PCInc_In  in  DATA_W  PC+2
Valid_Out  out  1  latched valid
Ctrl_Out  out  8  latched control, same packing as Ctrl_In
Flags_Out  out  4  latched flags
SelFlag_Out  out  3  latched select
WR_Out  out  REG_W  latched destination
ALUResult_Out  out  DATA_W  latched ALU result
RD2_Out  out  DATA_W  latched store data
BJAddr_Out  out  DATA_W  latched target
PCInc_Out  out  DATA_W  latched PC+2
Halted  out  1  sticky; 1 once a valid Halt has been latched
err  out  1  sticky; valid instruction with MemReadEn and MemWriteEn both set
StallCnt  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; state machine goes to RUN.
- State machine states: RUN, HALTED. All updates below occur on the rising edge of clk.
- RUN, Flush=1:
  - Valid_Out and Ctrl_Out clear to 0.
  - Data fields, Flags_Out, SelFlag_Out and WR_Out hold.
  - Stall is ignored.
- RUN, Flush=0, Stall=1: all registers hold.
- RUN, Flush=0, Stall=0 (load):
  - All fields load from their inputs. Latency is 1 cycle.
  - Ctrl_Out is forced to 0 when Valid_In=0, so an invalid slot never carries side effects.
- Transition RUN to HALTED: on a load with Valid_In=1 and Halt=1. Halted rises in the same edge as Ctrl_Out[0].
- HALTED:
  - All registers freeze, including Halt=1 on Ctrl_Out[0]. Stall, Flush and every input are ignored.
  - Exit is by reset only.
- err:
  - Set on a load with Valid_In=1, MemReadEn=1 and MemWriteEn=1.
  - The offending values are still latched.
  - Sticky until reset.
- Simultaneous Flush and Stall: Flush wins.
- Simultaneous Flush and a Halt on the inputs: the flush wins, no halt is latched, and the state stays RUN.
- Reset mid-stall or while HALTED: the block returns immediately to the reset values.

Optional Feature:
Macro EX_MEM_PERF_EN.
- Defined:
  - StallCnt increments by 1 on each edge in RUN with Stall=1, Flush=0 and Valid_Out=1.
  - It saturates at 16'hFFFF and does not count while HALTED.
  - Reset clears it to 0.
- Not defined: StallCnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset then load: rst 0 then 1; Valid_In=1, Ctrl_In=8'h84, ALUResult_In=16'h1234, WR_In=3'd5, one edge → Valid_Out=1, Ctrl_Out=8'h84, ALUResult_Out=16'h1234, WR_Out=5.
- Stall hold: after the load above, apply Stall=1 for 3 edges with ALUResult_In=16'hBEEF → outputs stay at 16'h1234. With EX_MEM_PERF_EN defined, StallCnt=3.
- Flush priority: Stall=1 and Flush=1 on one edge → Valid_Out=0, Ctrl_Out=0, ALUResult_Out stays 16'h1234, StallCnt unchanged.
- Invalid slot: Valid_In=0, Ctrl_In=8'hFF, one edge → Ctrl_Out=0, Valid_Out=0, Halted=0, err=0.
- Halt freeze: Valid_In=1, Ctrl_In=8'h01, PCInc_In=16'h0020 → Halted=1, Ctrl_Out[0]=1. Then drive Flush=1 and new data for 5 edges → all outputs unchanged. Assert rst=0 → all outputs 0.
- Error: Valid_In=1, Ctrl_In=8'h06 → err=1. Follow with legal loads → err remains 1 until rst=0.
